alt_vipcti131_common_unpack_stream: RTL and testbench

ALT_VIPCTI131_COMMON_UNPACK_STREAM -- requirements
Module: alt_vipcti131_common_unpack_stream

---
 rtl/alt_vipcti131_common_pkg.sv | 9 +
 rtl/alt_vipcti131_common_bit_extract.sv | 25 ++
 rtl/alt_vipcti131_common_unpack_stream.sv | 64 ++++++
 tb/tb_alt_vipcti131_common_unpack_stream.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alt_vipcti131_common_pkg.sv
// alt_vipcti131_common_pkg: shared sizing and parameter checks for the unpack stream
package alt_vipcti131_common_pkg;
  function automatic int fill_width(input int in_w, input int out_w);
    return $clog2(in_w + out_w - 1) + 1;
  endfunction
  function automatic bit widths_legal(input int in_w, input int out_w);
    return out_w >= 1 && out_w <= in_w;
  endfunction
endpackage

// File: rtl/alt_vipcti131_common_bit_extract.sv
// alt_vipcti131_common_bit_extract: drops extracted low bits from the residue and appends a new word above what remains
module alt_vipcti131_common_bit_extract import alt_vipcti131_common_pkg::*; #(
  parameter int DATA_WIDTH_IN = 128,
  parameter int DATA_WIDTH_OUT = 24,
  localparam int BW = DATA_WIDTH_IN + DATA_WIDTH_OUT - 1,
  localparam int FW = fill_width(DATA_WIDTH_IN, DATA_WIDTH_OUT)
) (
  input  logic [BW-1:0]            residue,
  input  logic [FW-1:0]            fill_left,
  input  logic [DATA_WIDTH_IN-1:0] data_in,
  input  logic                     extract,
  input  logic                     accept,
  input  logic                     drop,
  output logic [BW-1:0]            residue_next,
  output logic [FW-1:0]            fill_next
);
  logic [BW-1:0] shifted, incoming;
  // bits above fill are always zero, so OR is a safe append
  always_comb begin
    shifted = extract ? residue >> DATA_WIDTH_OUT : residue;
    incoming = accept ? BW'(data_in) << fill_left : '0;
    residue_next = drop ? '0 : shifted | incoming;
    fill_next = drop ? '0 : fill_left + (accept ? FW'(DATA_WIDTH_IN) : '0);
  end
endmodule

// File: rtl/alt_vipcti131_common_unpack_stream.sv
// alt_vipcti131_common_unpack_stream: unpacks wide memory words into narrow LSB-first user words with packet end handling
module alt_vipcti131_common_unpack_stream import alt_vipcti131_common_pkg::*; #(
  parameter int DATA_WIDTH_IN = 128,
  parameter int DATA_WIDTH_OUT = 24
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [DATA_WIDTH_IN-1:0]  data_in,
  input  logic                      eop_in,
  input  logic                      stall_in,
  output logic                      read,
  output logic [DATA_WIDTH_OUT-1:0] data_out,
  output logic                      eop_out,
  output logic                      write,
  input  logic                      stall_out,
  input  logic                      clear
);
  localparam int BW = DATA_WIDTH_IN + DATA_WIDTH_OUT - 1;
  localparam int FW = fill_width(DATA_WIDTH_IN, DATA_WIDTH_OUT);
  localparam logic [FW-1:0] OW = FW'(DATA_WIDTH_OUT);
  if (!widths_legal(DATA_WIDTH_IN, DATA_WIDTH_OUT)) begin : g_bad_widths
    $error("DATA_WIDTH_OUT must be in 1..DATA_WIDTH_IN");
  end
  logic [BW-1:0] residue, residue_next;
  logic [FW-1:0] fill_q, fill_left, fill_next;
  logic end_flag, slot_free, extract, accept, drop;
  assign slot_free = !write || !stall_out;
  assign extract = fill_q >= OW && slot_free;
  assign fill_left = fill_q - (extract ? OW : '0);
  assign read = !reset && !clear && !end_flag && fill_left < OW;
  assign accept = read && !stall_in;
  // last extract of a packet throws away the sub-word tail so the next packet starts word-aligned
  assign drop = extract && end_flag && fill_left < OW;
  alt_vipcti131_common_bit_extract #(
    .DATA_WIDTH_IN(DATA_WIDTH_IN),
    .DATA_WIDTH_OUT(DATA_WIDTH_OUT)
  ) u_bit_extract (
    .residue(residue),
    .fill_left(fill_left),
    .data_in(data_in),
    .extract(extract),
    .accept(accept),
    .drop(drop),
    .residue_next(residue_next),
    .fill_next(fill_next)
  );
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      residue <= '0;
      fill_q <= '0;
      end_flag <= 1'b0;
      write <= 1'b0;
      eop_out <= 1'b0;
      if (reset) data_out <= '0;
    end else begin
      residue <= residue_next;
      fill_q <= fill_next;
      end_flag <= !drop && (end_flag || (accept && eop_in));
      if (extract) data_out <= residue[DATA_WIDTH_OUT-1:0];
      write <= extract || (!slot_free && write);
      eop_out <= extract ? drop : !slot_free && eop_out;
    end
  end
endmodule

// File: tb/tb_alt_vipcti131_common_unpack_stream.sv
// tb_alt_vipcti131_common_unpack_stream: randomized bench against a bit-queue model of the unpacker
module tb_alt_vipcti131_common_unpack_stream;
  typedef struct {logic [127:0] d; bit e;} in_t;
  typedef struct {logic [23:0] d; bit e;} out_t;
  logic clk = 0, reset = 1, clear = 0, eop_in = 0, stall_in = 1, stall_out = 0;
  logic [127:0] data_in = '0;
  logic read, eop_out, write;
  logic [23:0] data_out;
  logic [31:0] p_din = '0;
  logic p_eop_in = 0, p_stall_in = 1, p_stall_out = 0, p_clear = 0;
  logic p_read, p_eop_out, p_write;
  logic [31:0] p_dout;
  int nvec = 0, nerr = 0, cyc = 0, first_acc, first_out, last_out, nout, neop;
  bit rnd = 0;
  bit bq[$];
  in_t wq[$];
  out_t exq[$];
  logic [32:0] pq[$];

  always #5 clk = ~clk;

  alt_vipcti131_common_unpack_stream #(.DATA_WIDTH_IN(128), .DATA_WIDTH_OUT(24)) dut (
    .clock(clk), .reset(reset), .data_in(data_in), .eop_in(eop_in), .stall_in(stall_in),
    .read(read), .data_out(data_out), .eop_out(eop_out), .write(write),
    .stall_out(stall_out), .clear(clear));

  alt_vipcti131_common_unpack_stream #(.DATA_WIDTH_IN(32), .DATA_WIDTH_OUT(32)) dut_pt (
    .clock(clk), .reset(reset), .data_in(p_din), .eop_in(p_eop_in), .stall_in(p_stall_in),
    .read(p_read), .data_out(p_dout), .eop_out(p_eop_out), .write(p_write),
    .stall_out(p_stall_out), .clear(p_clear));

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference: a plain bit queue, 24 bits popped at a time, tail dropped at packet end
  task automatic model_accept(input logic [127:0] d, input bit e);
    out_t o;
    for (int i = 0; i < 128; i++) bq.push_back(d[i]);
    while (bq.size() >= 24) begin
      for (int i = 0; i < 24; i++) o.d[i] = bq.pop_front();
      o.e = 0;
      exq.push_back(o);
    end
    if (e) begin
      o = exq.pop_back();
      o.e = 1;
      exq.push_back(o);
      bq.delete();
    end
  endtask

  task automatic tick();
    in_t w;
    out_t o;
    if (wq.size() != 0) begin
      data_in = wq[0].d;
      eop_in = wq[0].e;
    end
    stall_in = wq.size() == 0 || (rnd && $urandom_range(0, 3) == 0);
    if (rnd) begin
      stall_out = $urandom_range(0, 2) == 0;
      clear = $urandom_range(0, 40) == 0;
    end
    @(negedge clk);
    if (reset) begin
      bq.delete();
      exq.delete();
    end else begin
      if (write && !stall_out) begin
        if (exq.size() == 0) check("extra_output", exq.size(), 1);
        else begin
          o = exq.pop_front();
          check("data_out", data_out, o.d);
          check("eop_out", eop_out, o.e);
        end
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
        nout++;
        if (eop_out) neop++;
      end
      if (clear) begin
        bq.delete();
        exq.delete();
      end else if (read && !stall_in) begin
        w = wq.pop_front();
        model_accept(w.d, w.e);
        if (first_acc < 0) first_acc = cyc;
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && (wq.size() != 0 || exq.size() != 0 || write); i++) tick();
    check("drain_left", exq.size() + wq.size(), 0);
  endtask

  task automatic start();
    first_acc = -1;
    first_out = -1;
    nout = 0;
    neop = 0;
  endtask

  task automatic push_incr3();
    in_t w;
    for (int k = 0; k < 3; k++) begin
      for (int b = 0; b < 16; b++) w.d[8*b +: 8] = 8'(16 * k + b);
      w.e = k == 2;
      wq.push_back(w);
    end
  endtask

  task automatic push_rand(input int n, input bit last_eop);
    in_t w;
    for (int k = 0; k < n; k++) begin
      w.d = {$urandom, $urandom, $urandom, $urandom};
      w.e = last_eop && k == n - 1;
      wq.push_back(w);
    end
  endtask

  task automatic run_incr3();
    start();
    push_incr3();
    drain(100);
    check("burst_count", nout, 16);
    check("burst_gap", last_out - first_out, 15);
    check("burst_latency", first_out - first_acc, 2);
    check("burst_eop_count", neop, 1);
    check("burst_read_after", read, 1);
  endtask

  initial begin
    logic [23:0] d0;
    in_t w;
    int pfa, pfo, pearly;
    repeat (2) tick();
    check("rst_write", write, 0);
    check("rst_eop", eop_out, 0);
    check("rst_data", data_out, 0);
    check("rst_read", read, 0);
    reset = 0;
    #1;
    check("rst_read_release", read, 1);
    run_incr3();
    start();
    push_rand(1, 1);
    push_rand(1, 1);
    drain(100);
    check("single_count", nout, 10);
    check("single_eops", neop, 2);
    start();
    push_rand(3, 1);
    for (int i = 0; i < 50 && nout < 3; i++) tick();
    check("stall_pre_write", write, 1);
    d0 = data_out;
    stall_out = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("stall_data", data_out, d0);
      check("stall_write", write, 1);
      check("stall_read", read, 0);
    end
    stall_out = 0;
    drain(100);
    start();
    push_rand(1, 0);
    for (int i = 0; i < 50 && nout < 2; i++) tick();
    clear = 1;
    tick();
    clear = 0;
    check("clear_write", write, 0);
    check("clear_eop", eop_out, 0);
    #1;
    check("clear_read", read, 1);
    start();
    push_rand(1, 1);
    drain(100);
    check("clear_next_count", nout, 5);
    start();
    push_incr3();
    for (int i = 0; i < 50 && nout < 3; i++) tick();
    stall_out = 1;
    tick();
    reset = 1;
    tick();
    check("midrst_write", write, 0);
    check("midrst_eop", eop_out, 0);
    check("midrst_data", data_out, 0);
    reset = 0;
    stall_out = 0;
    wq.delete();
    run_incr3();
    start();
    rnd = 1;
    for (int k = 0; k < 40; k++) begin
      w.d = {$urandom, $urandom, $urandom, $urandom};
      w.e = k == 39 || $urandom_range(0, 3) == 0;
      wq.push_back(w);
    end
    drain(3000);
    rnd = 0;
    clear = 0;
    stall_out = 0;
    pfa = -1;
    pfo = -1;
    pearly = 0;
    for (int c = 0; c < 400; c++) begin
      p_din = $urandom;
      p_eop_in = $urandom_range(0, 3) == 0;
      p_stall_in = c >= 6 && $urandom_range(0, 2) == 0;
      p_stall_out = c >= 6 && $urandom_range(0, 2) == 0;
      @(negedge clk);
      if (p_write && !p_stall_out) begin
        if (pq.size() == 0) check("pt_extra", pq.size(), 1);
        else check("pt_word", {p_eop_out, p_dout}, pq.pop_front());
        if (pfo < 0) pfo = c;
        if (c < 6) pearly++;
      end
      if (p_read && !p_stall_in) begin
        pq.push_back({p_eop_in, p_din});
        if (pfa < 0) pfa = c;
      end
      @(posedge clk);
      #1;
    end
    check("pt_latency", pfo - pfa, 2);
    check("pt_full_rate", pearly, 4);
    p_stall_in = 1;
    p_stall_out = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (p_write) begin
        if (pq.size() == 0) check("pt_extra", pq.size(), 1);
        else check("pt_word", {p_eop_out, p_dout}, pq.pop_front());
      end
      @(posedge clk);
      #1;
    end
    check("pt_left", pq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
